// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM state encoding,
// word/strobe widths and the byte-lane merge used on stores.
package data_mem_pkg;

    localparam int WORD_W = 32;
    localparam int STRB_W = WORD_W / 8;
    localparam int CNT_W  = 4;   // wait counter, enough for LATENCY up to 15

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Replace only the byte lanes whose strobe bit is set; other bytes keep old_w.
    function automatic logic [WORD_W-1:0] merge_bytes(
        input logic [WORD_W-1:0] old_w,
        input logic [WORD_W-1:0] new_w,
        input logic [STRB_W-1:0] strb
    );
        logic [WORD_W-1:0] res;
        res = old_w;
        for (int i = 0; i < STRB_W; i++) begin
            if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// DEPTH x 32 word storage: synchronous byte-strobed write, registered read.
// The storage itself is never reset; only the read-data register is, and it
// can be cleared so the response bus returns to zero between transactions.
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter  int DEPTH = 64,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic              clr_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [STRB_W-1:0] wstrb_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    // Byte-strobed write into storage; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[idx_i] <= merge_bytes(mem_q[idx_i], wdata_i, wstrb_i);
    end

    // Read register: loaded on a load commit, cleared when the response is taken.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)   rdata_q <= '0;
        else if (re_i)  rdata_q <= mem_q[idx_i];
        else if (clr_i) rdata_q <= '0;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Registered multi-cycle data-memory responder with valid/ready request and
// response channels, one transaction outstanding at a time.
// Optional feature macro: DATA_MEM_RESP_ERR_EN -- flags misaligned or
// out-of-range accesses with rsp_err and suppresses their storage effect.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q;
    logic [IDX_W-1:0]  idx_q;
    logic [WORD_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;

    logic              accept, commit, done;
    logic              c_we, c_err;
    logic [IDX_W-1:0]  c_idx;
    logic [WORD_W-1:0] c_wdata;
    logic [STRB_W-1:0] c_wstrb;

    // Ready is gated by reset so it reads 0 while reset is held.
    assign req_ready = reset && (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);

    // With zero latency the commit happens on the accept edge, so the
    // commit path takes the live request instead of the latched copy.
    assign c_we    = (state_q == ST_IDLE) ? req_we                 : we_q;
    assign c_idx   = (state_q == ST_IDLE) ? req_addr[IDX_W+1:2]    : idx_q;
    assign c_wdata = (state_q == ST_IDLE) ? req_wdata              : wdata_q;
    assign c_wstrb = (state_q == ST_IDLE) ? req_wstrb              : wstrb_q;

    // Next-state, wait counter and handshake strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 0) begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the request on the accept edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (accept) begin
            we_q    <= req_we;
            idx_q   <= req_addr[IDX_W+1:2];
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
        end
    end

`ifdef DATA_MEM_RESP_ERR_EN
    logic req_err, aerr_q, err_q;

    // Misaligned, or any address bit set at or above 4*DEPTH.
    assign req_err = (req_addr[1:0] != 2'b00) || (req_addr[ADDR_W-1:IDX_W+2] != '0);
    assign c_err   = (state_q == ST_IDLE) ? req_err : aerr_q;

    // Error flag: latched at accept, published at commit, cleared when taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            aerr_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (accept) aerr_q <= req_err;
            if (commit)    err_q <= c_err;
            else if (done) err_q <= 1'b0;
        end
    end

    assign rsp_err = err_q;
`else
    // Alignment and upper address bits are ignored; accesses wrap modulo DEPTH.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[ADDR_W-1:IDX_W+2], req_addr[1:0]};
    assign c_err   = 1'b0;
    assign rsp_err = 1'b0;
`endif

    data_mem_array #(.DEPTH(DEPTH)) u_array (
        .clk_i   (clk),
        .rst_n_i (reset),
        .we_i    (commit && c_we && !c_err),
        .re_i    (commit && !c_we && !c_err),
        .clr_i   (done),
        .idx_i   (c_idx),
        .wdata_i (c_wdata),
        .wstrb_i (c_wstrb),
        .rdata_o (rsp_rdata)
    );

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder (slave) end of the core's data-memory interface; serves load/store requests from the processor's load/store path.
- Replaces the zero-wait combinational data memory with a registered, multi-cycle memory using valid/ready handshakes on separate request and response channels.
- Word-organised storage with byte-lane write strobes.
- One outstanding transaction at a time.

Parameters:
- DEPTH, 64, number of 32-bit words stored; power of two, minimum 2.
- LATENCY, 2, wait cycles between request acceptance and response; 0..15.
- ADDR_W, 32, request byte-address width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data.
- req_wstrb  input  4  byte-lane enables; bit i selects wdata[8i+7:8i].
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  32  load data; 0 for stores.
- rsp_err  output  1  access error (see Optional Feature).

Behaviour:
- States: IDLE, WAIT, RESP.
- Reset (reset=0, asynchronous):
  - state=IDLE, wait counter=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0 while reset is asserted.
  - Storage contents are not reset.
- Deassertion of reset is used synchronously. In IDLE, req_ready=1. In WAIT and RESP, req_ready=0.
- Accept: edge where req_valid && req_ready.
  - Latch we, addr, wdata and wstrb into internal registers.
  - LATENCY>0: go to WAIT with counter=LATENCY-1.
  - LATENCY=0: go straight to RESP.
- WAIT:
  - Decrement the counter each cycle.
  - On the edge where counter==0, go to RESP.
  - rsp_valid first reads 1 after edge t+LATENCY, where t is the accept edge.
- Commit (same edge that enters RESP):
  - Stores write only the lanes with a set strobe bit; other bytes are unchanged.
  - Loads register mem[index] into rsp_rdata.
  - index = addr[IDX_W+1:2], with IDX_W = log2(DEPTH).
- RESP:
  - rsp_valid=1.
  - rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready.
  - On that edge: rsp_valid=0, rsp_rdata=0, rsp_err=0, go to IDLE.
  - The next request is accepted no earlier than the following edge.
- Throughput: at most one transaction every LATENCY+2 cycles.
- Store with wstrb=4'b0000: no storage change, normal response.
- Load and store to the same word back to back: the load returns the post-store value.
- Reset mid-operation:
  - A transaction that has not committed is discarded; storage is untouched.
  - A committed store persists.
  - No response is produced after reset.
- Requester changing req_* while req_ready=0 has no effect.

Optional Feature:
- Macro: DATA_MEM_RESP_ERR_EN.
- Defined: rsp_err=1 when req_addr[1:0]!=0 or req_addr >= 4*DEPTH.
  - The erroring transaction performs no storage write.
  - rsp_rdata=0.
  - Response timing is unchanged.
- Undefined:
  - addr[1:0] are ignored.
  - Upper address bits above IDX_W+1 are ignored, so accesses wrap modulo DEPTH.
  - rsp_err is tied to 0.

Decomposition:
- Shared package data_mem_pkg:
  - State encoding for IDLE/WAIT/RESP (2 bits).
  - Word width 32 and strobe width 4.
  - Byte-lane merge function.
- Sub-module data_mem_array:
  - DEPTH x 32 storage with synchronous byte-strobed write and registered read.
  - Instantiated once.
  - FSM, counter and handshake logic stay in the top.

Test Plan:
- Reset, then store addr=0x10, wdata=0xDEADBEEF, wstrb=4'hF, LATENCY=2 -> rsp_valid rises 2 edges after accept; rsp_rdata=0; rsp_err=0.
- Then load 0x10 -> rsp_rdata=0xDEADBEEF.
- Store wdata=0x000000AA, wstrb=4'b0001 to 0x10, then load -> 0xDEADBEAA.
- Hold rsp_ready=0 for 5 cycles during a load response -> rsp_valid, rsp_rdata and rsp_err stable; req_ready=0 throughout.
- Release rsp_ready -> IDLE next edge; req_ready=1.
- With DATA_MEM_RESP_ERR_EN, store 0x12 and store 4*DEPTH -> rsp_err=1; a follow-up load of those words is unchanged.
- Without the macro, load at 4*DEPTH+0x10 -> returns mem[4].
- Assert reset during WAIT of a store to 0x20 -> rsp_valid=0 and req_ready=0 during reset; after release, load 0x20 returns its prior value.
- LATENCY=0 build: accept at edge t -> rsp_valid=1 after edge t.
- Issue 8 back-to-back store/load pairs -> correct data and exactly LATENCY+2 cycles per transaction.
